// File: rtl/myproject_udiv_pkg.sv
// rtl/myproject_udiv_pkg.sv - shared state encoding, default widths and counter sizing for the udiv block
package myproject_udiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } udiv_state_e;

    localparam int DEF_DIVIDEND_WIDTH = 10;
    localparam int DEF_DIVISOR_WIDTH  = 9;

    // Bits needed for an iteration counter that can hold 0..w.
    function automatic int udiv_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/myproject_udiv_step.sv
// rtl/myproject_udiv_step.sv - one combinational restoring-division step
module myproject_udiv_step #(
    parameter int DIVISOR_WIDTH = 9
) (
    input  logic [DIVISOR_WIDTH:0]   partial,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH-1:0] rem_next,
    output logic                     q_bit
);

    logic [DIVISOR_WIDTH+1:0] trial;

    // Subtract the divisor; keep the difference only if it is non-negative and fits the remainder width.
    // With a non-zero divisor a non-negative difference always fits; only divisor zero can overflow,
    // and that result is overridden by the zero-divisor forcing in the sequencer.
    always_comb begin
        trial    = {1'b0, partial} - {2'b00, divisor};
        q_bit    = ~trial[DIVISOR_WIDTH+1] & ~trial[DIVISOR_WIDTH];
        rem_next = q_bit ? trial[DIVISOR_WIDTH-1:0] : partial[DIVISOR_WIDTH-1:0];
    end

endmodule

// File: rtl/myproject_udiv_seq.sv
// rtl/myproject_udiv_seq.sv - iterative unsigned restoring divider (MYPROJECT_UDIV_ZERO_SHORTCUT_EN: zero divisor skips iterations)
module myproject_udiv_seq
    import myproject_udiv_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int CW = udiv_cnt_width(DIVIDEND_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DIVIDEND_WIDTH - 1);

    udiv_state_e               state_q, state_d;
    logic [DIVIDEND_WIDTH-1:0] dvd_q;
    logic [DIVIDEND_WIDTH-1:0] quo_q;
    logic [DIVISOR_WIDTH-1:0]  dvs_q;
    logic [DIVISOR_WIDTH-1:0]  rem_q;
    logic [CW-1:0]             cnt_q;
    logic                      dbz_q;

    logic [DIVISOR_WIDTH-1:0]  rem_next;
    logic                      q_bit;
    logic                      last_step;

    assign last_step = (cnt_q == LAST_STEP);

    myproject_udiv_step #(
        .DIVISOR_WIDTH(DIVISOR_WIDTH)
    ) u_step (
        .partial (({rem_q, dvd_q[DIVIDEND_WIDTH-1]})),
        .divisor (dvs_q),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef MYPROJECT_UDIV_ZERO_SHORTCUT_EN
                    state_d = (divisor == '0) ? ST_DONE : ST_BUSY;
`else
                    state_d = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, one quotient bit per BUSY cycle, zero-divisor forcing; results hold in DONE.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        rem_q <= '0;
                        cnt_q <= '0;
                        dbz_q <= (divisor == '0);
`ifdef MYPROJECT_UDIV_ZERO_SHORTCUT_EN
                        quo_q <= (divisor == '0) ? '1 : '0;
`else
                        quo_q <= '0;
`endif
                    end
                end
                ST_BUSY: begin
                    dvd_q <= {dvd_q[DIVIDEND_WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step && dbz_q) begin
                        quo_q <= '1;
                        rem_q <= '0;
                    end else begin
                        quo_q <= {quo_q[DIVIDEND_WIDTH-2:0], q_bit};
                        rem_q <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_myproject_udiv_seq.sv
// tb/tb_myproject_udiv_seq.sv - self-checking bench for myproject_udiv_seq
module tb_myproject_udiv_seq;

    localparam int DW    = 10;
    localparam int SW    = 9;
    localparam int NRND  = 2000;
    localparam int QMAX  = (1 << DW) - 1;
`ifdef MYPROJECT_UDIV_ZERO_SHORTCUT_EN
    localparam int ZLAT  = 1;
`else
    localparam int ZLAT  = DW + 1;
`endif

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    int checks   = 0;
    int failures = 0;

    int exp_a_q[$];
    int exp_b_q[$];

    myproject_udiv_seq #(
        .DIVIDEND_WIDTH(DW),
        .DIVISOR_WIDTH (SW)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with the zero-divisor convention.
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? QMAX : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? 0 : a % b;
    endfunction

    task automatic run_op(input string tag, input int a, input int b, input int stall);
        int n;
        int lat_exp;
        lat_exp = (b == 0) ? ZLAT : DW + 1;
        @(negedge ap_clk);
        chk({tag, "_rdy"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        dividend  = DW'(a);
        divisor   = SW'(b);
        out_ready = 1'b0;
        @(posedge ap_clk);
        #1 in_valid = 1'b0;
        @(negedge ap_clk);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk({tag, "_lat"}, n + 1, lat_exp);
        in_valid = 1'b1;
        dividend = DW'(3);
        divisor  = SW'(1);
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_hold_q"}, int'(quotient), ref_q(a, b));
            chk({tag, "_hold_r"}, int'(remainder), ref_r(a, b));
            chk({tag, "_hold_rdy"}, int'(in_ready), 0);
            chk({tag, "_hold_vld"}, int'(out_valid), 1);
            @(negedge ap_clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_q"}, int'(quotient), ref_q(a, b));
        chk({tag, "_r"}, int'(remainder), ref_r(a, b));
        chk({tag, "_dbz"}, int'(div_by_zero), (b == 0) ? 1 : 0);
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk({tag, "_vld_after"}, int'(out_valid), 0);
        chk({tag, "_rdy_after"}, int'(in_ready), 1);
    endtask

    initial begin
        int seen;
        int got;
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_rdy", int'(in_ready), 1);
        chk("rst_vld", int'(out_valid), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);

        run_op("d1000_9", 1000, 9, 0);
        run_op("d1023_1", 1023, 1, 0);
        run_op("d5_9", 5, 9, 0);
        run_op("d700_0", 700, 0, 0);
        run_op("d300_7", 300, 7, 5);

        // Reset pulse in the middle of an operation.
        @(negedge ap_clk);
        in_valid = 1'b1;
        dividend = DW'(1000);
        divisor  = SW'(9);
        @(posedge ap_clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #2;
        chk("rstmid_vld", int'(out_valid), 0);
        chk("rstmid_q", int'(quotient), 0);
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge ap_clk);
            if (out_valid) seen = 1;
        end
        out_ready = 1'b0;
        chk("rstmid_noresult", seen, 0);
        chk("rstmid_rdy", int'(in_ready), 1);
        run_op("d511_511", 511, 511, 0);

        // Random traffic with throttled consumer.
        got = 0;
        fork
            begin
                for (int i = 0; i < NRND; i++) begin
                    int a, b, t;
                    a = int'($urandom_range(0, QMAX));
                    case ($urandom_range(0, 7))
                        0:       b = 0;
                        1:       b = int'($urandom_range(1, 3));
                        2:       b = (1 << SW) - 1;
                        default: b = int'($urandom_range(1, (1 << SW) - 1));
                    endcase
                    repeat ($urandom_range(0, 2)) @(negedge ap_clk);
                    in_valid = 1'b1;
                    dividend = DW'(a);
                    divisor  = SW'(b);
                    t = 0;
                    while (!in_ready && t < 200) begin
                        @(negedge ap_clk);
                        t++;
                    end
                    if (t >= 200) begin
                        chk("rnd_accept_timeout", t, 0);
                        break;
                    end
                    exp_a_q.push_back(a);
                    exp_b_q.push_back(b);
                    @(negedge ap_clk);
                    in_valid = 1'b0;
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (got < NRND && cyc < 80000) begin
                    @(negedge ap_clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_a_q.size() == 0) begin
                            chk("rnd_dup", 1, 0);
                        end else begin
                            int a, b;
                            a = exp_a_q.pop_front();
                            b = exp_b_q.pop_front();
                            chk("rnd_q", int'(quotient), ref_q(a, b));
                            chk("rnd_r", int'(remainder), ref_r(a, b));
                            chk("rnd_dbz", int'(div_by_zero), (b == 0) ? 1 : 0);
                            if (b != 0) begin
                                chk("rnd_inv", int'(quotient) * b + int'(remainder), a);
                                chk("rnd_rlt", (int'(remainder) < b) ? 1 : 0, 1);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk("rnd_count", got, NRND);
        chk("rnd_left", exp_a_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
